// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - opcodes, status bit and FSM states for the sector-erase controller
package flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int WIP_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        WREN,
        GAP1,
        SE,
        GAP2,
        RDSR,
        GAP3,
        DONE
    } state_t;

endpackage

// File: rtl/spi_byte_shift.sv
// rtl/spi_byte_shift.sv - mode-0 SPI shifter, up to 32 bits per frame, sck = sys_clk/4
module spi_byte_shift (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_bits,
    input  logic        miso,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    output logic [7:0]  rx_data,
    output logic        shift_busy,
    output logic        shift_done
);

    logic [1:0]  ph;
    logic [5:0]  bits_left;
    logic [31:0] tx_shift;

    // High during ph3 of the last bit, so the caller can act on the same edge cs_n rises.
    assign shift_done = shift_busy && (ph == 2'd3) && (bits_left == 6'd0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_busy <= 1'b0;
            ph         <= 2'd0;
            bits_left  <= 6'd0;
            tx_shift   <= 32'h0;
            rx_data    <= 8'h00;
            sck        <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
        end else if (start) begin
            shift_busy <= 1'b1;
            ph         <= 2'd0;
            bits_left  <= tx_bits - 6'd1;
            tx_shift   <= {tx_data[30:0], 1'b0};
            sck        <= 1'b0;
            cs_n       <= 1'b0;
            mosi       <= tx_data[31];
        end else if (shift_busy) begin
            ph <= ph + 2'd1;
            unique case (ph)
                2'd1: begin
                    sck     <= 1'b1;
                    rx_data <= {rx_data[6:0], miso};
                end
                2'd3: begin
                    sck <= 1'b0;
                    if (shift_done) begin
                        shift_busy <= 1'b0;
                        cs_n       <= 1'b1;
                        mosi       <= 1'b0;
                    end else begin
                        mosi      <= tx_shift[31];
                        tx_shift  <= {tx_shift[30:0], 1'b0};
                        bits_left <= bits_left - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/flash_se_ctrl.sv
// rtl/flash_se_ctrl.sv - key-triggered WREN / SE / RDSR-poll sequencer for SPI NOR flash
module flash_se_ctrl #(
    parameter logic [23:0] SECTOR_ADDR = 24'h00_0000,
    parameter logic [7:0]  CS_GAP      = 8'd32,
    parameter logic [15:0] POLL_MAX    = 16'd60_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_flag,
    input  logic       miso,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] status
);

    import flash_pkg::*;

    state_t      state, state_next;
    logic [7:0]  gap_cnt;
    logic [15:0] poll_cnt;
    logic        gap_last;
    logic        finish_err;
    logic        start;
    logic [31:0] tx_data;
    logic [5:0]  tx_bits;
    logic        shift_busy;
    logic        shift_done;
    logic [7:0]  rx_data;

    assign gap_last = (gap_cnt == CS_GAP - 8'd1);

    spi_byte_shift u_shift (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .tx_data    (tx_data),
        .tx_bits    (tx_bits),
        .miso       (miso),
        .sck        (sck),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .shift_busy (shift_busy),
        .shift_done (shift_done)
    );

    // Each gap launches the next frame on its final cycle so cs_n is high exactly CS_GAP cycles.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        tx_data    = {OP_RDSR, 24'h00_0000};
        tx_bits    = 6'd16;
        finish_err = 1'b0;
        unique case (state)
            IDLE: if (key_flag) state_next = WREN;
            WREN: begin
                tx_data = {OP_WREN, 24'h00_0000};
                tx_bits = 6'd8;
                start   = !shift_busy;
                if (shift_done) state_next = GAP1;
            end
            GAP1: begin
                tx_data = {OP_SE, SECTOR_ADDR};
                tx_bits = 6'd32;
                if (gap_last) begin
                    start      = 1'b1;
                    state_next = SE;
                end
            end
            SE:   if (shift_done) state_next = GAP2;
            GAP2: if (gap_last) begin
                start      = 1'b1;
                state_next = RDSR;
            end
            RDSR: if (shift_done) state_next = GAP3;
            GAP3: if (gap_last) begin
                if (!status[WIP_BIT]) begin
                    state_next = DONE;
                end else if (poll_cnt == POLL_MAX) begin
                    state_next = DONE;
                    finish_err = 1'b1;
                end else begin
                    start      = 1'b1;
                    state_next = RDSR;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            gap_cnt  <= 8'd0;
            poll_cnt <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            status   <= 8'h00;
        end else begin
            state   <= state_next;
            gap_cnt <= ((state inside {GAP1, GAP2, GAP3}) && !gap_last) ? gap_cnt + 8'd1 : 8'd0;
            if (state == GAP2) begin
                poll_cnt <= 16'd0;
            end else if ((state == RDSR) && shift_done && (poll_cnt != 16'hFFFF)) begin
                poll_cnt <= poll_cnt + 16'd1;
            end
            if ((state == RDSR) && shift_done) status <= rx_data;
            done <= (state_next == DONE);
            busy <= !(state_next inside {IDLE, DONE});
            if ((state == IDLE) && key_flag) begin
                err <= 1'b0;
            end else if (state_next == DONE) begin
                err <= finish_err;
            end
        end
    end

endmodule

// File: tb/tb_flash_se_ctrl.sv
// tb/tb_flash_se_ctrl.sv - directed bench with a flash slave model and mode-0 bus monitor
module tb_flash_se_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_flag [2] = '{1'b0, 1'b0};
    logic       miso [2] = '{1'b0, 1'b0};
    logic       sck [2];
    logic       cs_n [2];
    logic       mosi [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];
    logic [7:0] status [2];

    always #5 sys_clk = ~sys_clk;

    flash_se_ctrl dut0 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .key_flag (key_flag[0]), .miso (miso[0]),
        .sck (sck[0]), .cs_n (cs_n[0]), .mosi (mosi[0]), .busy (busy[0]),
        .done (done[0]), .err (err[0]), .status (status[0])
    );

    flash_se_ctrl #(.CS_GAP(8'd1), .POLL_MAX(16'd4)) dut1 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .key_flag (key_flag[1]), .miso (miso[1]),
        .sck (sck[1]), .cs_n (cs_n[1]), .mosi (mosi[1]), .busy (busy[1]),
        .done (done[1]), .err (err[1]), .status (status[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flash model controls, written only by the stimulus block.
    logic       mon_en = 1'b0;
    int         busy_polls [2] = '{0, 0};
    logic [7:0] busy_val [2]   = '{8'h00, 8'h00};
    logic [7:0] final_val [2]  = '{8'h00, 8'h00};
    int         rdsr_base [2]  = '{0, 0};
    int         gap_exp [2]    = '{32, 1};

    // Monitor / model state, written only by the monitor block.
    logic        sck_p [2], cs_p [2], mosi_p [2], done_p [2], busy_p [2];
    logic        is_rdsr [2] = '{1'b0, 1'b0};
    logic        in_seq [2]  = '{1'b0, 1'b0};
    logic [31:0] cap [2]     = '{32'h0, 32'h0};
    logic [7:0]  resp_cur [2] = '{8'h00, 8'h00};
    int bitcnt [2] = '{0, 0};
    int since_rise [2] = '{0, 0};
    int gapc [2] = '{0, 0};
    int n_tx [2] = '{0, 0};
    int n_rdsr [2] = '{0, 0};
    int mosi_err [2] = '{0, 0};
    int per_err [2] = '{0, 0};
    int sckhi_err [2] = '{0, 0};
    int gap_err [2] = '{0, 0};
    int gap_chk [2] = '{0, 0};
    int done_err [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int busy_fall [2] = '{0, 0};
    logic [31:0] log_word [2][64];
    int          log_bits [2][64];

    always @(negedge sys_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_en) begin
                since_rise[d]++;
                if (!cs_n[d] && cs_p[d]) begin
                    if (in_seq[d]) begin
                        gap_chk[d]++;
                        if (gapc[d] != gap_exp[d]) gap_err[d]++;
                    end
                    bitcnt[d]  = 0;
                    cap[d]     = 32'h0;
                    is_rdsr[d] = 1'b0;
                end
                if (cs_n[d] && !cs_p[d]) begin
                    log_word[d][n_tx[d] % 64] = cap[d];
                    log_bits[d][n_tx[d] % 64] = bitcnt[d];
                    n_tx[d]++;
                    if (is_rdsr[d]) n_rdsr[d]++;
                    is_rdsr[d] = 1'b0;
                    miso[d]    = 1'b0;
                    gapc[d]    = 1;
                    in_seq[d]  = busy[d];
                end else if (cs_n[d]) begin
                    gapc[d]++;
                end
                if (!busy[d]) in_seq[d] = 1'b0;
                if (cs_n[d]) begin
                    if (sck[d]) sckhi_err[d]++;
                end else begin
                    if (sck[d] && !sck_p[d]) begin
                        if (mosi[d] !== mosi_p[d]) mosi_err[d]++;
                        if (bitcnt[d] > 0 && since_rise[d] != 4) per_err[d]++;
                        since_rise[d] = 0;
                        cap[d] = {cap[d][30:0], mosi[d]};
                        bitcnt[d]++;
                        if (bitcnt[d] == 8) begin
                            is_rdsr[d]  = (cap[d][7:0] == 8'h05);
                            resp_cur[d] = ((n_rdsr[d] - rdsr_base[d]) < busy_polls[d]) ? busy_val[d] : final_val[d];
                        end
                    end
                    if (!sck[d] && sck_p[d] && is_rdsr[d] && bitcnt[d] >= 8 && bitcnt[d] < 16)
                        miso[d] = resp_cur[d][15 - bitcnt[d]];
                end
                if (done[d]) begin
                    done_cnt[d]++;
                    if (done_p[d] || busy[d] || !busy_p[d]) done_err[d]++;
                end
                if (!busy[d] && busy_p[d]) busy_fall[d]++;
            end
            sck_p[d]  = sck[d];
            cs_p[d]   = cs_n[d];
            mosi_p[d] = mosi[d];
            done_p[d] = done[d];
            busy_p[d] = busy[d];
        end
    end

    task automatic pulse_key(input int d);
        key_flag[d] = 1'b1;
        @(negedge sys_clk);
        key_flag[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int first, input int limit, output int cyc);
        cyc = first;
        while (done[d] !== 1'b1 && cyc < limit) begin
            @(negedge sys_clk);
            cyc++;
        end
    endtask

    task automatic check_erase_frames(input string tag, input int base);
        check({tag, "_wren_word"}, log_word[0][base % 64], 32'h0000_0006);
        check({tag, "_wren_bits"}, log_bits[0][base % 64], 8);
        check({tag, "_se_word"}, log_word[0][(base + 1) % 64], 32'hD800_0000);
        check({tag, "_se_bits"}, log_bits[0][(base + 1) % 64], 32);
        check({tag, "_rdsr_word"}, log_word[0][(base + 2) % 64], 32'h0000_0500);
        check({tag, "_rdsr_bits"}, log_bits[0][(base + 2) % 64], 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c, t0, r0, g0, f0, d0;

    initial begin
        repeat (4) @(negedge sys_clk);
        check("rst_cs_n", cs_n[0], 1'b1);
        check("rst_sck", sck[0], 1'b0);
        check("rst_mosi", mosi[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        check("rst_err", err[0], 1'b0);
        check("rst_status", status[0], 8'h00);
        check("rst_cs_n_1", cs_n[1], 1'b1);
        sys_rst = 1'b0;
        mon_en  = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Single erase, WIP clear on first poll.
        busy_polls[0] = 0; final_val[0] = 8'h00;
        t0 = n_tx[0]; r0 = n_rdsr[0]; rdsr_base[0] = n_rdsr[0]; g0 = gap_chk[0]; f0 = busy_fall[0];
        pulse_key(0);
        check("t1_busy_rise", busy[0], 1'b1);
        check("t1_cs_still_high", cs_n[0], 1'b1);
        @(negedge sys_clk);
        check("t1_cs_low", cs_n[0], 1'b0);
        wait_done(0, 1, 2000, c);
        check("t1_len", c, 321);
        check("t1_err", err[0], 1'b0);
        check("t1_status", status[0], 8'h00);
        check("t1_busy_at_done", busy[0], 1'b0);
        check("t1_frames", n_tx[0] - t0, 3);
        check("t1_polls", n_rdsr[0] - r0, 1);
        check("t1_gaps", gap_chk[0] - g0, 2);
        check_erase_frames("t1", t0);
        @(negedge sys_clk);
        check("t1_done_low", done[0], 1'b0);
        check("t1_busy_fall", busy_fall[0] - f0, 1);
        repeat (5) @(negedge sys_clk);

        // Five busy polls (03) then 02.
        busy_polls[0] = 5; busy_val[0] = 8'h03; final_val[0] = 8'h02;
        t0 = n_tx[0]; r0 = n_rdsr[0]; rdsr_base[0] = n_rdsr[0]; g0 = gap_chk[0];
        pulse_key(0);
        @(negedge sys_clk);
        wait_done(0, 1, 3000, c);
        check("t2_len", c, 801);
        check("t2_err", err[0], 1'b0);
        check("t2_status", status[0], 8'h02);
        check("t2_polls", n_rdsr[0] - r0, 6);
        check("t2_frames", n_tx[0] - t0, 8);
        check("t2_gaps", gap_chk[0] - g0, 7);
        repeat (5) @(negedge sys_clk);

        // Poll timeout on the POLL_MAX=4, CS_GAP=1 instance.
        busy_polls[1] = 1000; busy_val[1] = 8'h01; final_val[1] = 8'h01;
        t0 = n_tx[1]; r0 = n_rdsr[1]; rdsr_base[1] = n_rdsr[1]; g0 = gap_chk[1];
        pulse_key(1);
        @(negedge sys_clk);
        check("t3_cs_low", cs_n[1], 1'b0);
        wait_done(1, 1, 3000, c);
        check("t3_len", c, 423);
        check("t3_err", err[1], 1'b1);
        check("t3_status", status[1], 8'h01);
        check("t3_polls", n_rdsr[1] - r0, 4);
        check("t3_gaps", gap_chk[1] - g0, 5);
        repeat (5) @(negedge sys_clk);

        // Extra key pulses mid-SE and on the done cycle are ignored.
        busy_polls[0] = 0; final_val[0] = 8'h00;
        t0 = n_tx[0]; rdsr_base[0] = n_rdsr[0]; f0 = busy_fall[0]; d0 = done_cnt[0];
        pulse_key(0);
        @(negedge sys_clk);
        repeat (100) @(negedge sys_clk);
        check("t4_in_se", cs_n[0], 1'b0);
        pulse_key(0);
        wait_done(0, 102, 2000, c);
        check("t4_len", c, 321);
        key_flag[0] = 1'b1;
        @(negedge sys_clk);
        key_flag[0] = 1'b0;
        check("t4_busy_after_done", busy[0], 1'b0);
        repeat (40) @(negedge sys_clk);
        check("t4_still_idle", busy[0], 1'b0);
        check("t4_cs_idle", cs_n[0], 1'b1);
        check("t4_frames", n_tx[0] - t0, 3);
        check("t4_busy_fall", busy_fall[0] - f0, 1);
        check("t4_done_count", done_cnt[0] - d0, 1);

        // Reset during bit 10 of SE, then a clean restart.
        t0 = n_tx[0];
        pulse_key(0);
        @(negedge sys_clk);
        repeat (105) @(negedge sys_clk);
        check("t5_pre_rst_cs", cs_n[0], 1'b0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("t5_rst_cs_n", cs_n[0], 1'b1);
        check("t5_rst_sck", sck[0], 1'b0);
        check("t5_rst_mosi", mosi[0], 1'b0);
        check("t5_rst_busy", busy[0], 1'b0);
        check("t5_rst_done", done[0], 1'b0);
        @(negedge sys_clk);
        check("t5_cut_bits", log_bits[0][(t0 + 1) % 64], 10);
        repeat (3) @(negedge sys_clk);
        final_val[0] = 8'h02;
        t0 = n_tx[0]; rdsr_base[0] = n_rdsr[0];
        pulse_key(0);
        @(negedge sys_clk);
        check("t5_restart_cs_low", cs_n[0], 1'b0);
        wait_done(0, 1, 2000, c);
        check("t5_len", c, 321);
        check("t5_err", err[0], 1'b0);
        check("t5_status", status[0], 8'h02);
        check("t5_frames", n_tx[0] - t0, 3);
        check_erase_frames("t5", t0);
        repeat (5) @(negedge sys_clk);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("mon%0d_mosi_stable", d), mosi_err[d], 0);
            check($sformatf("mon%0d_sck_period", d), per_err[d], 0);
            check($sformatf("mon%0d_sck_cs_high", d), sckhi_err[d], 0);
            check($sformatf("mon%0d_cs_gap", d), gap_err[d], 0);
            check($sformatf("mon%0d_done_busy", d), done_err[d], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
